// File: rtl/g_reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : g_reg_bus_pkg
// Description : Register-bank strobe bus widths, register addresses and the
//               initiator FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package g_reg_bus_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [ADDR_W-1:0] {
        g_t_klim                = 5'h00,
        g_t_kint                = 5'h01,
        g_t_kprop               = 5'h02,
        g_t_setpoint            = 5'h03,
        g_style_ctrl            = 5'h04,
        g_style_status          = 5'h08,
        g_style_pair_lo         = 5'h0C,
        g_style_main_reset_hold = 5'h1F
    } g_reg_addr_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Pair writes target an even/odd register pair, so the base is forced even.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic              pair_wr);
        return pair_wr ? {addr[ADDR_W-1:1], 1'b0} : addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/g_reg_initiator.sv
`default_nettype none
// ============================================================================
// Module      : g_reg_initiator
// Description : One-at-a-time register access initiator driving the bank's
//               active-low write/read strobes with setup/strobe/hold phases.
// Revision    : 1.0 - initial release
// ============================================================================
module g_reg_initiator
    import g_reg_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_pair,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                g_wrb,
    output logic                g_rdb,
    output logic [ADDR_W-1:0]   g_dout_w0x0f,
    output logic [2*DATA_W-1:0] din,
    output logic                n9_bit_write,
    input  logic [DATA_W-1:0]   g_dout
);

    localparam logic [3:0] c_setup_ld  = (SETUP_CYC > 0) ? 4'(SETUP_CYC - 1) : 4'd0;
    localparam logic [3:0] c_strobe_ld = 4'(STROBE_CYC - 1);
    localparam logic [3:0] c_hold_ld   = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

    state_t                r_state_q,     w_state_d;
    logic [3:0]            r_cnt_q,       w_cnt_d;
    logic                  r_write_q,     w_write_d;
    logic                  r_req_ready_q, w_req_ready_d;
    logic                  r_rsp_valid_q, w_rsp_valid_d;
    logic [DATA_W-1:0]     r_rsp_rdata_q, w_rsp_rdata_d;
    logic                  r_wrb_q,       w_wrb_d;
    logic                  r_rdb_q,       w_rdb_d;
    logic [ADDR_W-1:0]     r_addr_q,      w_addr_d;
    logic [2*DATA_W-1:0]   r_din_q,       w_din_d;
    logic                  r_n9_q,        w_n9_d;
    logic                  w_enter_strobe;
    logic                  w_enter_resp;
    logic                  w_strobe_wr;

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_write_d      = r_write_q;
        w_req_ready_d  = r_req_ready_q;
        w_rsp_valid_d  = r_rsp_valid_q;
        w_rsp_rdata_d  = r_rsp_rdata_q;
        w_wrb_d        = r_wrb_q;
        w_rdb_d        = r_rdb_q;
        w_addr_d       = r_addr_q;
        w_din_d        = r_din_q;
        w_n9_d         = r_n9_q;
        w_enter_strobe = 1'b0;
        w_enter_resp   = 1'b0;
        w_strobe_wr    = r_write_q;

        case (r_state_q)
            ST_IDLE: begin
                w_req_ready_d = 1'b1;
                if (req_valid && r_req_ready_q) begin
                    w_req_ready_d = 1'b0;
                    w_write_d     = req_write;
                    w_addr_d      = bank_addr(req_addr, req_pair & req_write);
                    w_din_d       = req_wdata;
                    w_n9_d        = req_pair & req_write;
                    w_rsp_rdata_d = '0;
                    if (SETUP_CYC == 0) begin
                        w_enter_strobe = 1'b1;
                        w_strobe_wr    = req_write;
                    end else begin
                        w_state_d = ST_SETUP;
                        w_cnt_d   = c_setup_ld;
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt_q == 4'd0) begin
                    w_enter_strobe = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt_q == 4'd0) begin
                    w_wrb_d = 1'b1;
                    w_rdb_d = 1'b1;
                    // Bank data is only valid while g_rdb is low, i.e. this cycle.
                    if (!r_write_q) begin
                        w_rsp_rdata_d = g_dout;
                    end
                    if (HOLD_CYC == 0) begin
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_d = ST_HOLD;
                        w_cnt_d   = c_hold_ld;
                    end
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt_q == 4'd0) begin
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_d = 1'b0;
                    w_req_ready_d = 1'b1;
                    w_state_d     = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_enter_strobe) begin
            w_state_d = ST_STROBE;
            w_cnt_d   = c_strobe_ld;
            w_wrb_d   = ~w_strobe_wr;
            w_rdb_d   = w_strobe_wr;
        end

        if (w_enter_resp) begin
            w_state_d     = ST_RESP;
            w_rsp_valid_d = 1'b1;
            w_addr_d      = '0;
            w_din_d       = '0;
            w_n9_d        = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_cnt_q       <= 4'd0;
            r_write_q     <= 1'b0;
            r_req_ready_q <= 1'b0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_rdata_q <= '0;
            r_wrb_q       <= 1'b1;
            r_rdb_q       <= 1'b1;
            r_addr_q      <= '0;
            r_din_q       <= '0;
            r_n9_q        <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_write_q     <= w_write_d;
            r_req_ready_q <= w_req_ready_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_wrb_q       <= w_wrb_d;
            r_rdb_q       <= w_rdb_d;
            r_addr_q      <= w_addr_d;
            r_din_q       <= w_din_d;
            r_n9_q        <= w_n9_d;
        end
    end

    assign req_ready    = r_req_ready_q;
    assign rsp_valid    = r_rsp_valid_q;
    assign rsp_rdata    = r_rsp_rdata_q;
    assign g_wrb        = r_wrb_q;
    assign g_rdb        = r_rdb_q;
    assign g_dout_w0x0f = r_addr_q;
    assign din          = r_din_q;
    assign n9_bit_write = r_n9_q;

endmodule
`default_nettype wire

// File: tb/tb_g_reg_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_g_reg_initiator
// Description : Self-checking bench for g_reg_initiator (default phases and a
//               minimal-phase instance) with a behavioural bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_g_reg_initiator;
    import g_reg_bus_pkg::*;

    localparam int c_setup  = 1;
    localparam int c_strobe = 2;
    localparam int c_hold   = 1;
    localparam int c_lat    = c_setup + c_strobe + c_hold;

    logic        sysclk;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_pair;
    logic [4:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        g_wrb, g_rdb, n9_bit_write;
    logic [4:0]  g_dout_w0x0f;
    logic [63:0] din;
    logic [31:0] g_dout;

    logic        req_valid_z, req_ready_z, req_write_z, req_pair_z;
    logic [4:0]  req_addr_z;
    logic [63:0] req_wdata_z;
    logic        rsp_valid_z, rsp_ready_z;
    logic [31:0] rsp_rdata_z;
    logic        g_wrb_z, g_rdb_z, n9_bit_write_z;
    logic [4:0]  g_dout_w0x0f_z;
    logic [63:0] din_z;
    logic [31:0] g_dout_z;

    logic [31:0] bank [32];
    int checks   = 0;
    int failures = 0;

    assign g_dout   = !g_rdb   ? bank[g_dout_w0x0f]   : 32'hBAD0_BAD0;
    assign g_dout_z = !g_rdb_z ? bank[g_dout_w0x0f_z] : 32'hBAD0_BAD0;

    g_reg_initiator #(.SETUP_CYC(c_setup), .STROBE_CYC(c_strobe), .HOLD_CYC(c_hold)) dut (
        .sysclk(sysclk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_pair(req_pair), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .g_wrb(g_wrb), .g_rdb(g_rdb), .g_dout_w0x0f(g_dout_w0x0f), .din(din),
        .n9_bit_write(n9_bit_write), .g_dout(g_dout)
    );

    g_reg_initiator #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dut_z (
        .sysclk(sysclk), .reset(reset),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
        .req_pair(req_pair_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
        .g_wrb(g_wrb_z), .g_rdb(g_rdb_z), .g_dout_w0x0f(g_dout_w0x0f_z), .din(din_z),
        .n9_bit_write(n9_bit_write_z), .g_dout(g_dout_z)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_vec(input bit wrb, input bit rdb, input logic [4:0] a,
                                            input logic [63:0] d, input bit n9, input bit rv,
                                            input bit rr);
        return {54'd0, wrb, rdb, a, d, n9, rv, rr};
    endfunction

    function automatic logic [127:0] bus_vec();
        return {54'd0, g_wrb, g_rdb, g_dout_w0x0f, din, n9_bit_write, rsp_valid, req_ready};
    endfunction

    // Reference: what the bank should see and what comes back for one access.
    function automatic void ref_model(input bit wr, input bit pr, input logic [4:0] a,
                                      output logic [4:0] ea, output bit en9,
                                      output logic [31:0] erd);
        en9 = wr && pr;
        ea  = en9 ? 5'(a - (a % 2)) : a;
        erd = wr ? 32'd0 : bank[a];
    endfunction

    always @(negedge sysclk) begin
        if (!reset) begin
            check("strobe_exclusive", {127'd0, g_wrb | g_rdb}, 128'd1);
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge sysclk);
            k++;
        end
        check("req_ready_wait", {127'd0, req_ready}, 128'd1);
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge sysclk);
            k++;
        end
        check("rsp_valid_wait", {127'd0, rsp_valid}, 128'd1);
    endtask

    task automatic do_access(input bit wr, input bit pr, input logic [4:0] a,
                             input logic [63:0] wd, input logic [4:0] ea, input bit en9,
                             input logic [31:0] erd, input int wait_cyc);
        wait_ready();
        req_valid = 1'b1; req_write = wr; req_pair = pr; req_addr = a; req_wdata = wd;
        @(posedge sysclk);
        @(negedge sysclk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_pair = 1'($urandom);
        req_addr  = 5'($urandom); req_wdata = {$urandom, $urandom};
        for (int n = 0; n <= c_lat; n++) begin
            bit strobe, busy;
            if (n > 0) @(negedge sysclk);
            strobe = (n >= c_setup) && (n < c_setup + c_strobe);
            busy   = (n < c_lat);
            check($sformatf("bus n=%0d a=%0d wr=%0d", n, a, wr), bus_vec(),
                  mk_vec(!(wr && strobe), !(!wr && strobe), busy ? ea : 5'd0,
                         busy ? wd : 64'd0, busy && en9, n == c_lat, 1'b0));
        end
        check("rsp_rdata", {96'd0, rsp_rdata}, {96'd0, erd});
        for (int w = 0; w < wait_cyc; w++) begin
            @(negedge sysclk);
            check("rsp_hold", {rsp_valid, req_ready, rsp_rdata}, {1'b1, 1'b0, erd});
        end
        rsp_ready = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        rsp_ready = 1'b0;
        check("rsp_done", {rsp_valid, req_ready}, 2'b01);
    endtask

    typedef struct {
        bit          wr;
        bit          pr;
        logic [4:0]  a;
        logic [63:0] wd;
        logic [31:0] bankv;
        logic [4:0]  ea;
        bit          en9;
        logic [31:0] erd;
        int          wt;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [4:0]  ea;
        bit          en9;
        logic [31:0] erd;

        tbl[0] = '{1'b1, 1'b0, 5'b01100, 64'h0_A5A50F0F, 32'd0, 5'b01100, 1'b0, 32'd0, 0};
        tbl[1] = '{1'b0, 1'b0, 5'b01010, 64'd0, 32'h12345678, 5'b01010, 1'b0, 32'h12345678, 1};
        tbl[2] = '{1'b1, 1'b1, 5'b00011, 64'hDEADBEEF_CAFEF00D, 32'd0, 5'b00010, 1'b1, 32'd0, 2};
        tbl[3] = '{1'b0, 1'b1, 5'b00111, 64'h1111_2222_3333_4444, 32'h0BADF00D, 5'b00111, 1'b0,
                   32'h0BADF00D, 0};
        tbl[4] = '{1'b1, 1'b1, 5'b11110, 64'h01234567_89ABCDEF, 32'd0, 5'b11110, 1'b1, 32'd0, 3};

        for (int i = 0; i < 32; i++) bank[i] = $urandom;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_pair = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        req_valid_z = 1'b0; req_write_z = 1'b0; req_pair_z = 1'b0; req_addr_z = '0;
        req_wdata_z = '0; rsp_ready_z = 1'b0;

        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check("reset_state", bus_vec(), mk_vec(1'b1, 1'b1, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0));
        check("reset_rdata", {96'd0, rsp_rdata}, 128'd0);
        reset = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        check("post_reset", bus_vec(), mk_vec(1'b1, 1'b1, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1));
        check("post_reset_z", {126'd0, req_ready_z, rsp_valid_z}, 128'b10);

        for (int i = 0; i < 5; i++) begin
            if (!tbl[i].wr) bank[tbl[i].a] = tbl[i].bankv;
            do_access(tbl[i].wr, tbl[i].pr, tbl[i].a, tbl[i].wd, tbl[i].ea, tbl[i].en9,
                      tbl[i].erd, tbl[i].wt);
        end

        for (int i = 0; i < 30; i++) begin
            bit          wr, pr;
            logic [4:0]  a;
            logic [63:0] wd;
            wr = 1'($urandom); pr = 1'($urandom); a = 5'($urandom); wd = {$urandom, $urandom};
            ref_model(wr, pr, a, ea, en9, erd);
            do_access(wr, pr, a, wd, ea, en9, erd, int'($urandom_range(0, 3)));
        end

        // Backpressure with a second request already waiting.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_pair = 1'b0; req_addr = 5'd5; req_wdata = 64'h55;
        @(posedge sysclk);
        @(negedge sysclk);
        req_write = 1'b0; req_addr = 5'b01000; req_wdata = 64'h0;
        wait_rsp();
        for (int w = 0; w < 10; w++) begin
            @(negedge sysclk);
            check("bp_hold", {rsp_valid, req_ready, rsp_rdata}, {1'b1, 1'b0, 32'd0});
        end
        rsp_ready = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        rsp_ready = 1'b0;
        check("bp_handshake", {rsp_valid, req_ready}, 2'b01);
        @(posedge sysclk);
        @(negedge sysclk);
        req_valid = 1'b0;
        check("bp_second_accept", {req_ready, g_dout_w0x0f, n9_bit_write}, {1'b0, 5'b01000, 1'b0});
        wait_rsp();
        check("bp_second_rdata", {96'd0, rsp_rdata}, {96'd0, bank[8]});
        rsp_ready = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        rsp_ready = 1'b0;

        // Reset on the first strobe cycle of a write drops the access.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_pair = 1'b0; req_addr = 5'b01100;
        req_wdata = 64'hA5;
        @(posedge sysclk);
        @(negedge sysclk);
        req_valid = 1'b0;
        @(negedge sysclk);
        check("rst_in_strobe", {127'd0, g_wrb}, 128'd0);
        reset = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        check("rst_mid_op", bus_vec(), mk_vec(1'b1, 1'b1, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        check("rst_release", bus_vec(), mk_vec(1'b1, 1'b1, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1));
        for (int w = 0; w < 10; w++) begin
            @(negedge sysclk);
            check("rst_no_rsp", {127'd0, rsp_valid}, 128'd0);
        end

        // Minimal-phase instance: read then write.
        for (int j = 0; j < 2; j++) begin
            int k;
            k = 0;
            while (!req_ready_z && k < 20) begin
                @(negedge sysclk);
                k++;
            end
            check("z_ready", {127'd0, req_ready_z}, 128'd1);
            bank[6] = 32'hC0FFEE00 + 32'(j);
            req_valid_z = 1'b1; req_write_z = 1'(j); req_pair_z = 1'b0; req_addr_z = 5'd6;
            req_wdata_z = 64'h77;
            @(posedge sysclk);
            @(negedge sysclk);
            req_valid_z = 1'b0;
            check("z_strobe", {125'd0, g_rdb_z, g_wrb_z, rsp_valid_z},
                  {125'd0, 1'(j), ~1'(j), 1'b0});
            @(negedge sysclk);
            check("z_resp", {93'd0, g_rdb_z, g_wrb_z, rsp_valid_z, rsp_rdata_z},
                  {93'd0, 1'b1, 1'b1, 1'b1, (j == 0) ? bank[6] : 32'd0});
            rsp_ready_z = 1'b1;
            @(posedge sysclk);
            @(negedge sysclk);
            rsp_ready_z = 1'b0;
            check("z_done", {126'd0, rsp_valid_z, req_ready_z}, 128'b01);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
